// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing control for a 5-stage pipe: Execute forwarding selects,
// load-use stall, branch flush, and an FSM that freezes the front end during UDIV/MUL.
module pipeline_hazard_controller #(
    parameter int DIV_CYCLES = 16,
    parameter int MUL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RS1_D,
    input  logic [4:0] RS2_D,
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_E,
    input  logic       ResultSrcE,
    input  logic       RegWriteM,
    input  logic [4:0] RD_M,
    input  logic       RegWriteW,
    input  logic [4:0] RD_W,
    input  logic       PCSrcE,
    input  logic       MultiStartE,
    input  logic       MultiIsDivE,
    input  logic       DivByZeroE,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MultiBusy,
    output logic       MultiDone,
    output logic [4:0] MultiCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);
    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);

    logic [1:0] state;
    logic [4:0] count;
    logic       start_ok;
    logic       multi_stall;
    logic       lw_stall;

    // A taken branch squashes the op in Execute, so it must not start the FSM.
    assign start_ok    = MultiStartE & ~PCSrcE;
    assign multi_stall = ((state == IDLE) & start_ok) | (state == BUSY);
    assign lw_stall    = ResultSrcE & (RD_E != 5'd0) & ((RD_E == RS1_D) | (RD_E == RS2_D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        if (MultiIsDivE & DivByZeroE) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            count <= MultiIsDivE ? DIV_LOAD : MUL_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (count == 5'd0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        MultiBusy  = 1'b0;
        MultiDone  = 1'b0;
        MultiCount = 5'd0;
        if (!rst) begin
            if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E) begin
                ForwardA_E = 2'b10;
            end else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) begin
                ForwardA_E = 2'b01;
            end
            if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E) begin
                ForwardB_E = 2'b10;
            end else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) begin
                ForwardB_E = 2'b01;
            end

            // Freeze beats flush: the held ID/EX op must not be turned into a bubble.
            if (multi_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end

            MultiBusy  = (state == BUSY);
            MultiDone  = (state == DONE);
            MultiCount = count;
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (Fetch/Decode/Execute/Memory/Writeback).
- Drives the Execute-stage forwarding selects (ForwardA_E/ForwardB_E) and resolves load-use hazards with a stall.
- Flushes on taken branches (PCSrcE).
- Sequences multi-cycle UDIV/MUL in Execute with an FSM and down-counter, freezing the front of the pipe until the result is ready.

Parameters:
- DIV_CYCLES, 16, number of BUSY cycles for UDIV; legal range 1..31.
- MUL_CYCLES, 2, number of BUSY cycles for MUL; legal range 1..31.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RS1_D  in  5  source register 1 of the instruction in Decode.
- RS2_D  in  5  source register 2 of the instruction in Decode.
- RS1_E  in  5  source register 1 in Execute.
- RS2_E  in  5  source register 2 in Execute.
- RD_E  in  5  destination register in Execute.
- ResultSrcE  in  1  1 = the instruction in Execute is a load.
- RegWriteM  in  1  Memory-stage write enable.
- RD_M  in  5  Memory-stage destination register.
- RegWriteW  in  1  Writeback-stage write enable.
- RD_W  in  5  Writeback-stage destination register.
- PCSrcE  in  1  branch taken, resolved in Execute.
- MultiStartE  in  1  the instruction in Execute is UDIV or MUL.
- MultiIsDivE  in  1  1 = UDIV, 0 = MUL; qualified by MultiStartE.
- DivByZeroE  in  1  UDIV divisor is zero; qualified by MultiStartE & MultiIsDivE.
- ForwardA_E  out  2  operand A select: 00 = register file, 01 = ResultW, 10 = ALU_ResultM.
- ForwardB_E  out  2  operand B select; same encoding as ForwardA_E.
- StallF  out  1  hold PC.
- StallD  out  1  hold the IF/ID register.
- StallE  out  1  hold the ID/EX register.
- FlushD  out  1  clear the IF/ID register to a bubble.
- FlushE  out  1  clear the ID/EX register to a bubble.
- MultiBusy  out  1  FSM is in BUSY.
- MultiDone  out  1  one-cycle pulse: multi-cycle result valid in Execute this cycle.
- MultiCount  out  5  current down-counter value.

Behaviour:
- Reset: when rst=1 at a clock edge, state <= IDLE and counter <= 0.
  - While rst=1, all outputs are forced to 0 (Forward = 00, all stalls/flushes/busy/done/count = 0).
- Forwarding (combinational), evaluated for A using RS1_E and for B using RS2_E:
  - Select 10 if RegWriteM, RD_M != 0 and RD_M == RSx_E.
  - Otherwise select 01 if RegWriteW, RD_W != 0 and RD_W == RSx_E.
  - Otherwise select 00.
  - Memory stage has priority over Writeback. Register 0 never forwards.
- Load-use stall: lwStall = ResultSrcE & (RD_E != 0) & (RD_E == RS1_D | RD_E == RS2_D).
  - Effect: StallF = StallD = 1 and FlushE = 1, inserting exactly one bubble.
- Branch: PCSrcE = 1 sets FlushD = FlushE = 1 in the same cycle.
  - PCSrcE overrides lwStall: StallF = StallD = 0.
- multiStall = (state == IDLE & MultiStartE & !PCSrcE) | (state == BUSY).
  - multiStall sets StallF = StallD = StallE = 1 and forces FlushE = 0 and FlushD = 0.
  - Priority order: rst > multiStall > PCSrcE > lwStall.
- FSM states IDLE, BUSY, DONE; transitions:
  - IDLE -> DONE: MultiStartE & MultiIsDivE & DivByZeroE. This is a one-cycle stall; the result is defined by the ALU.
  - IDLE -> BUSY: MultiStartE and not the divide-by-zero case. Counter loads DIV_CYCLES-1 for UDIV, MUL_CYCLES-1 for MUL.
  - IDLE stays in IDLE if PCSrcE = 1 or MultiStartE = 0.
  - BUSY: counter decrements each cycle; when counter == 0, go to DONE.
  - DONE: MultiDone = 1 and no stall, so Execute advances at this edge; next state is always IDLE.
- Latency:
  - UDIV/MUL total stall cycles = 1 + N, where N = DIV_CYCLES or MUL_CYCLES.
  - The op occupies Execute for N + 2 cycles.
  - Divide-by-zero: 1 stall cycle; the op occupies Execute for 2 cycles.
- Outputs: MultiBusy = (state == BUSY); MultiCount = counter. No wrap: the counter never decrements below 0.
- Reset mid-operation: the FSM returns to IDLE at the next edge and all stalls drop.
  - The Execute op is discarded by the pipeline reset; no MultiDone pulse is produced.
- A new MultiStartE is only accepted in IDLE; it is ignored in DONE (a back-to-back op is re-seen in IDLE on the next cycle).

Test Plan:
1. Forwarding: RegWriteM=1, RD_M=3, RegWriteW=1, RD_W=3, RS1_E=3, RS2_E=5 -> ForwardA_E=10, ForwardB_E=00. Same with RD_M=0 -> ForwardA_E=01.
2. Load-use: ResultSrcE=1, RD_E=4, RS2_D=4 -> StallF=StallD=FlushE=1 for exactly one cycle. Repeat with RD_E=0 -> no stall.
3. Branch vs load-use: PCSrcE=1 with lwStall conditions true -> FlushD=FlushE=1, StallF=StallD=0.
4. UDIV with DIV_CYCLES=16: MultiStartE=1, MultiIsDivE=1 -> StallF/D/E high for 17 cycles, MultiCount 15..0, MultiDone pulses in cycle 18, then IDLE.
5. UDIV by zero -> 1 stall cycle, MultiDone on the next cycle, MultiBusy never asserted. MUL with MUL_CYCLES=2 -> 3 stall cycles, then MultiDone.
6. rst=1 asserted at MultiCount=7 during UDIV -> next cycle all outputs 0, state IDLE; after rst drops, a fresh UDIV restarts at count 15.
